mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM stage of the MIPS pipeline, directly downstream of EX.
- Latches EX's Result (ALU result / effective address), Rdata2 (store data) and Ins.
- Performs load/store through a req/ack data-memory port, and hands the write-back value plus the instruction to WB.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- DMEM_TIMEOUT, 16, max cycles waiting for dmem_ack before abort with error; 0 disables the timeout.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- valid_in  in  1  EX outputs valid this cycle
- Ins  in  32  instruction from EX
- Result  in  32  EX result / effective address
- Rdata2  in  32  store data
- stall  out  1  block not accepting; upstream holds its outputs
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_ack  in  1  request completed; dmem_rdata valid
- dmem_rdata  in  32  load data word
- valid_out  out  1  one-cycle pulse: WB outputs valid
- Ins_out  out  32  instruction passed to WB
- WBdata  out  32  load result, or Result for non-memory ops
- addr_err  out  1  pulse with valid_out: misaligned or timed-out access

Behaviour:
- Reset: state IDLE; stall, dmem_req, dmem_we, valid_out and addr_err = 0; dmem_addr, dmem_be, dmem_wdata, Ins_out and WBdata = 0.
- Accept: valid_in & !stall latches Ins, Result and Rdata2. stall = (state != IDLE).
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. All other opcodes are non-memory.
- Non-memory op:
  - Next cycle: valid_out = 1, WBdata = Result, Ins_out = Ins.
  - Latency 1; state stays IDLE.
- Byte lanes are little-endian: byte k = bits[8k+7:8k], k = addr[1:0].
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 0.
- Store enables: SB be = 1<<k, wdata = {4{Rdata2[7:0]}}; SH be = 0011/1100, wdata = {2{Rdata2[15:0]}}; SW be = 1111.
- Loads: be per size (same pattern as stores). LB/LH sign-extend the selected lane; LBU/LHU zero-extend; LW takes the full word.
- FSM IDLE -> BUSY:
  - Aligned memory op accepted: next cycle dmem_req = 1, addr/be/we/wdata registered, state BUSY.
  - BUSY holds req and all request signals stable until dmem_ack is sampled 1.
  - On that edge: req = 0, state IDLE, valid_out = 1. Loads also set WBdata = extended rdata; stores set WBdata = 0.
  - Zero-wait memory (ack in first req cycle): valid_out 2 cycles after accept.
- New accept is allowed in the same cycle valid_out is high, giving back-to-back loads.
- dmem_ack while dmem_req = 0 is ignored.
- Timeout (DMEM_TIMEOUT > 0): counter increments each BUSY cycle without ack. At DMEM_TIMEOUT: req dropped, state IDLE, valid_out = 1, addr_err = 1, WBdata = 0.
- Reset mid-transaction: immediate return to IDLE, req dropped, no valid_out; a later ack is ignored.
- valid_in while stall = 1: inputs are not sampled; upstream must hold them.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - A misaligned memory op issues no dmem_req.
  - Next cycle: valid_out = 1, addr_err = 1, WBdata = 0; no state change (latency 1).
- Undefined:
  - Alignment is forced: LH/SH addr[0], LW/SW addr[1:0] are treated as 0, and the access proceeds normally.
  - addr_err is driven only by the timeout.

Test Plan:
- ADD Ins (opcode 0x00), Result = 0x12345678 -> next cycle valid_out = 1, WBdata = 0x12345678, dmem_req never asserted.
- LB, Result = 0x00000103, dmem_rdata = 0x80FF7F01, ack after 2 wait cycles -> dmem_addr = 0x100, be = 1000, stall high 3 cycles, WBdata = 0xFFFFFF80. Repeat as LBU -> WBdata = 0x00000080.
- SH, Result = 0x202, Rdata2 = 0xAAAABEEF, zero-wait ack -> dmem_we = 1, be = 1100, wdata = 0xBEEFBEEF, valid_out at accept+2, WBdata = 0.
- LW, Result = 0x202:
  - With MEM_ALIGN_CHECK_EN -> no req, addr_err = 1 at accept+1.
  - Without -> dmem_addr = 0x200, be = 1111, addr_err = 0.
- LW, ack never returned, DMEM_TIMEOUT = 4 -> req high 4 cycles, then valid_out = 1, addr_err = 1, stall drops.
- LW in BUSY, RST pulsed, then ack = 1 -> outputs all zero after reset, no valid_out; a subsequent ADD completes in 1 cycle.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MIPS MEM stage driving a req/ack data-memory port, with an optional response timeout.
// Build option MEM_ALIGN_CHECK_EN: misaligned accesses fault with addr_err instead of being force-aligned.
module mem_access #(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_in,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] Ins_out,
  output logic [31:0] WBdata,
  output logic        addr_err
);
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam int TW = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((DMEM_TIMEOUT > 0) ? (DMEM_TIMEOUT - 1) : 0);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  function automatic logic f_is_mem(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: f_is_mem = 1'b1;
      default:                                                  f_is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic f_is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: f_is_store = 1'b1;
      default:             f_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f_size(input logic [5:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: f_size = SZ_H;
      OP_LW, OP_SW:         f_size = SZ_W;
      default:              f_size = SZ_B;
    endcase
  endfunction

  // Lane k selects the byte/half; LB/LH sign-extend, LBU/LHU zero-extend, stores return 0.
  function automatic logic [31:0] f_load_ext(input logic [5:0] op, input logic [1:0] k,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (k)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = k[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   f_load_ext = {{24{b[7]}}, b};
      OP_LBU:  f_load_ext = {24'h000000, b};
      OP_LH:   f_load_ext = {{16{h[15]}}, h};
      OP_LHU:  f_load_ext = {16'h0000, h};
      OP_LW:   f_load_ext = word;
      default: f_load_ext = 32'h00000000;
    endcase
  endfunction

  state_t          r_state;
  logic [TW-1:0]   r_cnt;
  logic [5:0]      r_op;
  logic [1:0]      r_k;
  logic [31:0]     r_ins;
  logic [5:0]      w_op;
  logic            w_is_mem;
  logic            w_is_store;
  logic [1:0]      w_size;
  logic [1:0]      w_k;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_load_data;

  assign stall = (r_state == S_BUSY);

  // Decode the incoming op into lane, byte enables and lane-replicated store data.
  always_comb begin
    w_op       = Ins[31:26];
    w_is_mem   = f_is_mem(w_op);
    w_is_store = f_is_store(w_op);
    w_size     = f_size(w_op);
`ifdef MEM_ALIGN_CHECK_EN
    w_k = Result[1:0];
    if (w_size == SZ_H) begin
      w_misalign = Result[0];
    end else if (w_size == SZ_W) begin
      w_misalign = |Result[1:0];
    end else begin
      w_misalign = 1'b0;
    end
`else
    w_misalign = 1'b0;
    case (w_size)
      SZ_B:    w_k = Result[1:0];
      SZ_H:    w_k = {Result[1], 1'b0};
      default: w_k = 2'b00;
    endcase
`endif
    case (w_size)
      SZ_B:    w_be = 4'b0001 << w_k;
      SZ_H:    w_be = w_k[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
    if (!w_is_store) begin
      w_wdata = 32'h00000000;
    end else begin
      case (w_size)
        SZ_B:    w_wdata = {4{Rdata2[7:0]}};
        SZ_H:    w_wdata = {2{Rdata2[15:0]}};
        default: w_wdata = Rdata2;
      endcase
    end
    w_load_data = f_load_ext(r_op, r_k, dmem_rdata);
  end

  // Stage FSM: accept, issue the memory request, and retire to WB on ack or timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= 6'h00;
      r_k        <= 2'b00;
      r_ins      <= 32'h00000000;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h00000000;
      dmem_be    <= 4'b0000;
      dmem_wdata <= 32'h00000000;
      valid_out  <= 1'b0;
      addr_err   <= 1'b0;
      Ins_out    <= 32'h00000000;
      WBdata     <= 32'h00000000;
    end else begin
      valid_out <= 1'b0;
      addr_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            if (!w_is_mem) begin
              valid_out <= 1'b1;
              WBdata    <= Result;
              Ins_out   <= Ins;
            end else if (w_misalign) begin
              valid_out <= 1'b1;
              addr_err  <= 1'b1;
              WBdata    <= 32'h00000000;
              Ins_out   <= Ins;
            end else begin
              r_state    <= S_BUSY;
              r_cnt      <= '0;
              r_op       <= w_op;
              r_k        <= w_k;
              r_ins      <= Ins;
              dmem_req   <= 1'b1;
              dmem_we    <= w_is_store;
              dmem_addr  <= {Result[31:2], 2'b00};
              dmem_be    <= w_be;
              dmem_wdata <= w_wdata;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            r_state   <= S_IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            valid_out <= 1'b1;
            WBdata    <= w_load_data;
            Ins_out   <= r_ins;
          end else if ((DMEM_TIMEOUT != 0) && (r_cnt == TLIM)) begin
            r_state   <= S_IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            valid_out <= 1'b1;
            addr_err  <= 1'b1;
            WBdata    <= 32'h00000000;
            Ins_out   <= r_ins;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table with hand-computed expectations, scoreboard of in-flight ops,
// a wait-state memory responder, and hand-written reset/ack-ignore sequences.
module tb_mem_access;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] ins = 32'h0;
  logic [31:0] result = 32'h0;
  logic [31:0] rdata2 = 32'h0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        valid_out;
  logic [31:0] ins_out;
  logic [31:0] wbdata;
  logic        addr_err;

  mem_access #(.DMEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .valid_in(valid_in), .Ins(ins), .Result(result), .Rdata2(rdata2),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .valid_out(valid_out), .Ins_out(ins_out), .WBdata(wbdata), .addr_err(addr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] result;
    logic [31:0] rdata2;
    logic [31:0] rdata;
    int          wt;
    logic [31:0] wb;
    logic        err;
    int          reqc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_wait = 0;
  logic [31:0] mem_rdata = 32'h0;
  int   mem_cnt = 0;
  logic mem_auto = 1'b1;
  logic manual_ack = 1'b0;
  int   req_cnt = 0;
  int   stall_cnt = 0;
  logic [31:0] cap_addr = 32'h0;
  logic [3:0]  cap_be = 4'h0;
  logic        cap_we = 1'b0;
  logic [31:0] cap_wdata = 32'h0;
  sb_t  e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [31:0] i, input logic [31:0] r, input logic [31:0] d2,
                     input logic [31:0] rd, input int wt, input logic [31:0] wb, input logic err,
                     input int reqc, input logic [31:0] addr, input logic [3:0] be, input logic we,
                     input logic [31:0] wdata, input int lat);
    vec_t v;
    v.ins = i; v.result = r; v.rdata2 = d2; v.rdata = rd; v.wt = wt; v.wb = wb; v.err = err;
    v.reqc = reqc; v.addr = addr; v.be = be; v.we = we; v.wdata = wdata; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {27'h0, stall, dmem_req, dmem_we, valid_out, addr_err}, 32'h0);
    chk({tag, "_addr"}, dmem_addr, 32'h0);
    chk({tag, "_be"}, {28'h0, dmem_be}, 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_insout"}, ins_out, 32'h0);
    chk({tag, "_wbdata"}, wbdata, 32'h0);
  endtask

  // Drive one op once the stage is free; its expectations join the scoreboard.
  task automatic drive(input vec_t v);
    int guard;
    sb_t s;
    guard = 0;
    @(negedge CLK);
    while (stall && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (stall) chk("drive_stall_stuck", {31'h0, stall}, 32'h0);
    ins = v.ins; result = v.result; rdata2 = v.rdata2; valid_in = 1'b1;
    mem_wait = v.wt; mem_rdata = v.rdata;
    s.v = v; s.acc = cyc;
    @(posedge CLK);
    #1;
    sbq.push_back(s);
    valid_in = 1'b0;
    ins = $urandom(); result = $urandom(); rdata2 = $urandom();
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory responder: ack after mem_wait idle request cycles (or manual ack when mem_auto is off).
  always @(negedge CLK) begin
    if (!mem_auto) begin
      dmem_ack = manual_ack;
      mem_cnt = 0;
    end else if (dmem_req) begin
      dmem_ack = (mem_cnt == mem_wait);
      dmem_rdata = dmem_ack ? mem_rdata : 32'h0BAD0BAD;
      mem_cnt++;
    end else begin
      dmem_ack = 1'b0;
      mem_cnt = 0;
    end
  end

  // Monitor: count request/stall cycles and compare each retired op against the scoreboard.
  always @(negedge CLK) begin
    if (RST) begin
      req_cnt = 0;
      stall_cnt = 0;
    end else begin
      if (dmem_req) begin
        if (req_cnt == 0) begin
          cap_addr = dmem_addr; cap_be = dmem_be; cap_we = dmem_we; cap_wdata = dmem_wdata;
        end
        req_cnt++;
      end
      if (stall) stall_cnt++;
      if (valid_out) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid_out", {31'h0, valid_out}, 32'h0);
        end else begin
          e = sbq.pop_front();
          chk("wbdata", wbdata, e.v.wb);
          chk("ins_out", ins_out, e.v.ins);
          chk("addr_err", {31'h0, addr_err}, {31'h0, e.v.err});
          chk("latency", 32'(cyc - e.acc), 32'(e.v.lat));
          chk("req_cycles", 32'(req_cnt), 32'(e.v.reqc));
          chk("stall_cycles", 32'(stall_cnt), 32'(e.v.reqc));
          if (e.v.reqc > 0) begin
            chk("dmem_addr", cap_addr, e.v.addr);
            chk("dmem_be", {28'h0, cap_be}, {28'h0, e.v.be});
            chk("dmem_we", {31'h0, cap_we}, {31'h0, e.v.we});
            if (e.v.we) chk("dmem_wdata", cap_wdata, e.v.wdata);
          end
        end
        req_cnt = 0;
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int guard;
    vec_t addv;
    //   ins           result        rdata2        rdata         wt   wb            err   reqc addr          be       we    wdata         lat
    add(32'h00221820, 32'h12345678, 32'h0,        32'h0,        0,   32'h12345678, 1'b0, 0,   32'h0,        4'b0000, 1'b0, 32'h0,        1);
    add(32'h80430000, 32'h00000103, 32'h0,        32'h80FF7F01, 2,   32'hFFFFFF80, 1'b0, 3,   32'h00000100, 4'b1000, 1'b0, 32'h0,        4);
    add(32'h90430000, 32'h00000103, 32'h0,        32'h80FF7F01, 2,   32'h00000080, 1'b0, 3,   32'h00000100, 4'b1000, 1'b0, 32'h0,        4);
    add(32'hA4430000, 32'h00000202, 32'hAAAABEEF, 32'h12345678, 0,   32'h00000000, 1'b0, 1,   32'h00000200, 4'b1100, 1'b1, 32'hBEEFBEEF, 2);
`ifdef MEM_ALIGN_CHECK_EN
    add(32'h8C430000, 32'h00000202, 32'h0,        32'hCAFEF00D, 1,   32'h00000000, 1'b1, 0,   32'h0,        4'b0000, 1'b0, 32'h0,        1);
`else
    add(32'h8C430000, 32'h00000202, 32'h0,        32'hCAFEF00D, 1,   32'hCAFEF00D, 1'b0, 2,   32'h00000200, 4'b1111, 1'b0, 32'h0,        3);
`endif
    add(32'h84000000, 32'h00000402, 32'h0,        32'h9ABC1234, 0,   32'hFFFF9ABC, 1'b0, 1,   32'h00000400, 4'b1100, 1'b0, 32'h0,        2);
    add(32'h94000000, 32'h00000400, 32'h0,        32'h9ABC8765, 0,   32'h00008765, 1'b0, 1,   32'h00000400, 4'b0011, 1'b0, 32'h0,        2);
    add(32'hA0000000, 32'h00000301, 32'h000000A5, 32'h0,        1,   32'h00000000, 1'b0, 2,   32'h00000300, 4'b0010, 1'b1, 32'hA5A5A5A5, 3);
    add(32'hAC000000, 32'h00000500, 32'hDEADBEEF, 32'h0,        3,   32'h00000000, 1'b0, 4,   32'h00000500, 4'b1111, 1'b1, 32'hDEADBEEF, 5);
    add(32'h8C000000, 32'h00000600, 32'h0,        32'h55555555, 255, 32'h00000000, 1'b1, 4,   32'h00000600, 4'b1111, 1'b0, 32'h0,        5);
    add(32'h80000000, 32'h00000700, 32'h0,        32'h80FF7F01, 0,   32'h00000001, 1'b0, 1,   32'h00000700, 4'b0001, 1'b0, 32'h0,        2);
    add(32'h3C000000, 32'h89AB0000, 32'h0,        32'h0,        0,   32'h89AB0000, 1'b0, 0,   32'h0,        4'b0000, 1'b0, 32'h0,        1);
    add(32'h00000025, 32'h00000001, 32'h0,        32'h0,        0,   32'h00000001, 1'b0, 0,   32'h0,        4'b0000, 1'b0, 32'h0,        1);

    repeat (2) @(negedge CLK);
    #1;
    chk_zero("por");
    @(negedge CLK);
    RST = 1'b0;

    // Ops are driven as soon as stall drops, so loads retire and issue back-to-back.
    foreach (vecs[i]) drive(vecs[i]);

    guard = 0;
    while (sbq.size() > 0 && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    chk("sb_drain", 32'(sbq.size()), 32'h0);

    // Reset in the middle of an outstanding load; a late ack must be ignored.
    mem_auto = 1'b0;
    manual_ack = 1'b0;
    @(negedge CLK);
    ins = 32'h8C000000; result = 32'h00000800; valid_in = 1'b1;
    @(negedge CLK);
    valid_in = 1'b0;
    guard = 0;
    while (!dmem_req && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    chk("midrst_req_seen", {31'h0, dmem_req}, 32'h1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge CLK);
    RST = 1'b0;
    manual_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("late_ack_vout", {31'h0, valid_out}, 32'h0);
      chk("late_ack_req", {31'h0, dmem_req}, 32'h0);
    end
    manual_ack = 1'b0;
    mem_auto = 1'b1;

    addv = vecs[0];
    addv.result = 32'h0F0F0F0F;
    addv.wb = 32'h0F0F0F0F;
    drive(addv);
    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    chk("post_rst_drain", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
